// File: rtl/gates_pkg.sv
// Shared mode encoding, all_out bit layout and the gate evaluation functions
// used by both the block and its bench model.
package gates_pkg;

    localparam int MODE_W  = 3;
    localparam int MAX_N   = 8;
    localparam int N_FUNCS = 6;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_NAND = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5
    } mode_e;

    localparam mode_e MODE_LAST = MODE_XNOR;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_NAND = 2;
    localparam int IDX_NOR  = 3;
    localparam int IDX_XOR  = 4;
    localparam int IDX_XNOR = 5;

    // Only the low n bits of v take part; the rest are ignored.
    function automatic logic [N_FUNCS-1:0] eval_all(input logic [MAX_N-1:0] v, input int n);
        logic a, o, x;
        logic [N_FUNCS-1:0] r;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                a = a & v[i];
                o = o | v[i];
                x = x ^ v[i];
            end
        end
        r           = '0;
        r[IDX_AND]  = a;
        r[IDX_OR]   = o;
        r[IDX_NAND] = ~a;
        r[IDX_NOR]  = ~o;
        r[IDX_XOR]  = x;
        r[IDX_XNOR] = ~x;
        return r;
    endfunction

    function automatic logic eval_gate(input logic [MAX_N-1:0] v, input int n,
                                       input logic [MODE_W-1:0] m);
        logic [N_FUNCS-1:0] r;
        r = eval_all(v, n);
        if (m > MODE_LAST)
            return 1'b0;
        return r[m];
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        return (m == MODE_LAST) ? MODE_AND : mode_e'(m + 3'd1);
    endfunction

endpackage

// File: rtl/gates_multimode_debounce.sv
// Pushbutton synchronizer and debouncer; press pulses for one cycle, combinationally,
// on the same edge at which the stable level is accepted as high.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          btn_st_q, btn_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_comb begin
        btn_st_d = btn_st_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if (s2_q == btn_st_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            btn_st_d = s2_q;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Release is accepted the same way but is not an event.
        press = accept & s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            btn_st_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            btn_st_q <= btn_st_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/gates_multimode.sv
// Multi-mode gate block: registers AND/OR/NAND/NOR/XOR/XNOR of the synchronized inputs
// and drives the selected one; mode steps on a debounced press or an auto-scan tick.
module gates_multimode
    import gates_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int DEB_CYCLES  = 4,
    parameter int AUTO_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in_bits,
    input  logic              btn_next,
    output logic              gate_out,
    output logic [N_FUNCS-1:0] all_out,
    output logic [MODE_W-1:0] mode,
    output logic              mode_strobe
);

    logic [N_IN-1:0]    in_s1_q, in_s2_q;
    mode_e              mode_q, mode_d;
    logic               strobe_q, strobe_d;
    logic               gate_q, gate_d;
    logic [N_FUNCS-1:0] all_q, all_d;
    logic               press, tick, advance;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_next),
        .press  (press)
    );

    assign advance = press | tick;

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            localparam logic [AW-1:0] ACNT_MAX = AW'(AUTO_PERIOD - 1);
            logic [AW-1:0] acnt_q, acnt_d;

            assign tick = (acnt_q == ACNT_MAX);

            // A press restarts the period so the next tick is a full period away.
            always_comb begin
                acnt_d = advance ? '0 : acnt_q + AW'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    acnt_q <= '0;
                else
                    acnt_q <= acnt_d;
            end
        end else begin : g_no_auto
            assign tick = 1'b0;
        end
    endgenerate

    always_comb begin
        mode_d   = advance ? next_mode(mode_q) : mode_q;
        strobe_d = advance;
        all_d    = eval_all(MAX_N'(in_s2_q), N_IN);
        gate_d   = eval_gate(MAX_N'(in_s2_q), N_IN, mode_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_s1_q  <= '0;
            in_s2_q  <= '0;
            mode_q   <= MODE_AND;
            strobe_q <= 1'b0;
            gate_q   <= 1'b0;
            all_q    <= '0;
        end else begin
            in_s1_q  <= in_bits;
            in_s2_q  <= in_s1_q;
            mode_q   <= mode_d;
            strobe_q <= strobe_d;
            gate_q   <= gate_d;
            all_q    <= all_d;
        end
    end

    assign gate_out    = gate_q;
    assign all_out     = all_q;
    assign mode        = mode_q;
    assign mode_strobe = strobe_q;

endmodule

// File: tb/tb_gates_multimode.sv
// Directed bench: u_a (N_IN=3, no auto-scan) for evaluation, debounce, wrap and reset;
// u_b (N_IN=8, AUTO_PERIOD=8) for width and auto-scan behaviour.
module tb_gates_multimode;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_a;
    logic       btn_a;
    logic       gate_a, strb_a;
    logic [5:0] all_a;
    logic [2:0] mode_a;
    logic [7:0] in_b;
    logic       btn_b;
    logic       gate_b, strb_b;
    logic [5:0] all_b;
    logic [2:0] mode_b;

    int checks = 0;
    int errors = 0;

    gates_multimode #(.N_IN(3), .DEB_CYCLES(4), .AUTO_PERIOD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_bits(in_a), .btn_next(btn_a),
        .gate_out(gate_a), .all_out(all_a), .mode(mode_a), .mode_strobe(strb_a)
    );

    gates_multimode #(.N_IN(8), .DEB_CYCLES(4), .AUTO_PERIOD(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_bits(in_b), .btn_next(btn_b),
        .gate_out(gate_b), .all_out(all_b), .mode(mode_b), .mode_strobe(strb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle at the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_a(input logic [2:0] exp_mode);
        btn_a = 1'b1;
        tick(6);
        chk("press_mode", 8'(mode_a), 8'(exp_mode));
        chk("press_strobe", 8'(strb_a), 8'd1);
        btn_a = 1'b0;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0;
        in_a  = 3'b000;
        btn_a = 1'b0;
        in_b  = 8'h00;
        btn_b = 1'b0;
        tick(2);
        chk("rst_all", 8'(all_a), 8'h00);
        chk("rst_gate", 8'(gate_a), 8'h00);
        chk("rst_mode", 8'(mode_a), 8'h00);
        chk("rst_strobe", 8'(strb_a), 8'h00);

        rst_n = 1'b1;
        tick(1);
        chk("first_edge_all", 8'(all_a), 8'b101100);

        in_a = 3'b111;
        tick(2);
        chk("lat_not_yet", 8'(all_a), 8'b101100);
        tick(1);
        chk("all_111", 8'(all_a), 8'b010011);
        chk("gate_and_111", 8'(gate_a), 8'd1);
        chk("mode0", 8'(mode_a), 8'd0);
        in_a = 3'b000;
        tick(3);
        chk("all_000", 8'(all_a), 8'b101100);
        chk("gate_and_000", 8'(gate_a), 8'd0);

        // Glitch of 3 cycles: rejected
        btn_a = 1'b1;
        tick(3);
        btn_a = 1'b0;
        tick(8);
        chk("glitch_mode", 8'(mode_a), 8'd0);
        chk("glitch_strobe", 8'(strb_a), 8'd0);

        // Held 10 cycles: mode changes at edge 6
        btn_a = 1'b1;
        tick(5);
        chk("held_e5_mode", 8'(mode_a), 8'd0);
        tick(1);
        chk("held_e6_mode", 8'(mode_a), 8'd1);
        chk("held_e6_strobe", 8'(strb_a), 8'd1);
        tick(1);
        chk("held_e7_strobe", 8'(strb_a), 8'd0);
        chk("held_e7_mode", 8'(mode_a), 8'd1);
        tick(3);
        btn_a = 1'b0;
        tick(10);
        chk("release_mode", 8'(mode_a), 8'd1);

        // Wrap through 5 back to 0, then on to XOR
        press_a(3'd2);
        press_a(3'd3);
        press_a(3'd4);
        press_a(3'd5);
        press_a(3'd0);
        press_a(3'd1);
        press_a(3'd2);
        press_a(3'd3);
        press_a(3'd4);
        in_a = 3'b110;
        tick(3);
        chk("xor_110_gate", 8'(gate_a), 8'd0);
        chk("all_110", 8'(all_a), 8'b100110);
        in_a = 3'b111;
        tick(3);
        chk("xor_111_gate", 8'(gate_a), 8'd1);

        // Reach mode 3, then reset mid-debounce with cnt=2
        press_a(3'd5);
        press_a(3'd0);
        press_a(3'd1);
        press_a(3'd2);
        press_a(3'd3);
        btn_a = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mode", 8'(mode_a), 8'd0);
        chk("async_rst_all", 8'(all_a), 8'd0);
        chk("async_rst_gate", 8'(gate_a), 8'd0);
        chk("async_rst_strobe", 8'(strb_a), 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("held_rst_e5", 8'(mode_a), 8'd0);
        tick(1);
        chk("held_rst_e6", 8'(mode_a), 8'd1);
        tick(1);
        chk("held_rst_single", 8'(mode_a), 8'd1);
        btn_a = 1'b0;
        tick(8);

        // Auto-scan and 8-bit width on u_b
        rst_n = 1'b0;
        in_b  = 8'hFE;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("w8_all_FE", 8'(all_b), 8'b010110);
        chk("w8_gate_and", 8'(gate_b), 8'd0);
        tick(4);
        chk("auto_e7", 8'(mode_b), 8'd0);
        tick(1);
        chk("auto_e8", 8'(mode_b), 8'd1);
        chk("auto_e8_strobe", 8'(strb_b), 8'd1);
        tick(1);
        chk("auto_e9_strobe", 8'(strb_b), 8'd0);
        tick(7);
        chk("auto_e16", 8'(mode_b), 8'd2);
        tick(2);
        btn_b = 1'b1;
        tick(5);
        chk("coinc_e23", 8'(mode_b), 8'd2);
        tick(1);
        chk("coinc_e24", 8'(mode_b), 8'd3);
        chk("coinc_e24_strobe", 8'(strb_b), 8'd1);
        tick(1);
        chk("coinc_e25", 8'(mode_b), 8'd3);
        chk("coinc_e25_strobe", 8'(strb_b), 8'd0);
        tick(6);
        chk("next_tick_e31", 8'(mode_b), 8'd3);
        tick(1);
        chk("next_tick_e32", 8'(mode_b), 8'd4);
        tick(1);
        chk("w8_gate_xor", 8'(gate_b), 8'd1);
        btn_b = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
